sha256_job_scheduler: RTL and testbench



---
 rtl/sha256_job_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_sha256_job_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_job_scheduler.sv
// Job sequencer for a folded double-SHA-256 hasher: issues one nonce per LOOP
// cycles, retires each a fixed latency later and queues winning nonces.
module sha256_job_scheduler #(
    parameter int LOOP_LOG2  = 2,
    parameter int DIFFICULTY = 15,
    parameter int PIPE_LAT   = 130,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_midstate,
    input  logic [95:0]  job_tail,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic         abort,
    output logic [5:0]   h_cnt,
    output logic         h_feedback,
    output logic [255:0] h_state,
    output logic [511:0] h_data,
    input  logic [255:0] h_hash,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic         job_done,
    output logic         busy,
    output logic         overflow
);

    localparam int LOOP  = 1 << LOOP_LOG2;
    localparam int DLY_W = $clog2(PIPE_LAT + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int MEM_N = 1 << PTR_W;

    localparam logic [5:0]       CNT_LAST   = 6'(LOOP - 1);
    localparam logic [DLY_W-1:0] DLY_FIRST  = DLY_W'(PIPE_LAT);
    localparam logic [DLY_W-1:0] DLY_PERIOD = DLY_W'(LOOP - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [255:0]       h_state_q, h_state_d;
    logic [511:0]       h_data_q, h_data_d;
    logic [32:0]        issue_left_q, issue_left_d;
    logic [31:0]        outstanding_q, outstanding_d;
    logic [31:0]        retire_nonce_q, retire_nonce_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic               overflow_q, overflow_d;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [31:0]        mem_q [MEM_N];

    logic               issue;
    logic               retire;
    logic               hit;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push_ok;
    logic               drop;
    logic [5:0]         cnt_wrap;
    logic               hash_unused;

    // Only the leading DIFFICULTY bits of the hash matter; the rest is folded away.
    assign hash_unused = ^h_hash;

    assign cnt_wrap   = (cnt_q == CNT_LAST) ? 6'd0 : cnt_q + 6'd1;
    assign issue      = (state_q == ST_ISSUE) && (cnt_q == 6'd0);
    // Issues are strictly periodic, so retirements are too: first one PIPE_LAT
    // after the first issue, then every LOOP cycles until nothing is in flight.
    assign retire     = (state_q != ST_IDLE) && (delay_q == '0) && (outstanding_q != 32'd0);
    assign hit        = retire && (h_hash[255 -: DIFFICULTY] == '0);

    assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = found_ready && !fifo_empty;
    assign push_ok    = hit && (!fifo_full || pop);
    assign drop       = hit && fifo_full && !pop;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        h_state_d      = h_state_q;
        h_data_d       = h_data_q;
        issue_left_d   = issue_left_q;
        retire_nonce_d = retire_nonce_q;
        delay_d        = delay_q;
        overflow_d     = overflow_q | drop;
        outstanding_d  = outstanding_q + 32'(issue) - 32'(retire);

        if (retire) begin
            delay_d        = DLY_PERIOD;
            retire_nonce_d = retire_nonce_q + 32'd1;
        end else if ((state_q != ST_IDLE) && (delay_q != '0)) begin
            delay_d = delay_q - DLY_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 6'd0;
                if (job_valid) begin
                    state_d        = ST_ISSUE;
                    h_state_d      = job_midstate;
                    h_data_d       = {32'h0000_0280, 320'h0, 32'h8000_0000,
                                      job_nonce_start, job_tail};
                    issue_left_d   = {1'b0, job_nonce_end - job_nonce_start} + 33'd1;
                    outstanding_d  = 32'd0;
                    retire_nonce_d = job_nonce_start;
                    delay_d        = DLY_FIRST;
                    overflow_d     = 1'b0;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_wrap;
                if (issue) begin
                    issue_left_d = issue_left_q - 33'd1;
                end
                if ((issue && (issue_left_q == 33'd1)) || abort) begin
                    state_d = ST_DRAIN;
                end else if (cnt_wrap == 6'd0) begin
                    // Present the next nonce so it is on h_data in its issue cycle.
                    h_data_d[127:96] = h_data_q[127:96] + 32'd1;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_wrap;
                if (outstanding_q == 32'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 6'd0;
            h_state_q      <= '0;
            h_data_q       <= '0;
            issue_left_q   <= '0;
            outstanding_q  <= '0;
            retire_nonce_q <= '0;
            delay_q        <= '0;
            overflow_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            h_state_q      <= h_state_d;
            h_data_q       <= h_data_d;
            issue_left_q   <= issue_left_d;
            outstanding_q  <= outstanding_d;
            retire_nonce_q <= retire_nonce_d;
            delay_q        <= delay_d;
            overflow_q     <= overflow_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= retire_nonce_q;
        end
    end

    assign job_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign job_done    = (state_q == ST_DRAIN) && (outstanding_q == 32'd0);
    assign h_cnt       = cnt_q;
    assign h_feedback  = (cnt_q != 6'd0);
    assign h_state     = h_state_q;
    assign h_data      = h_data_q;
    assign found_valid = !fifo_empty;
    assign found_nonce = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed bench for sha256_job_scheduler with a delay-line hasher stub.
module tb_sha256_job_scheduler;

    localparam int PL = 20;
    localparam logic [255:0] HIT_HASH  = {16'h0000, {240{1'b1}}};
    localparam logic [255:0] MISS_HASH = {16'h0001, 240'h0};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         job_valid, job_ready, abort, h_feedback;
    logic [255:0] job_midstate, h_state, h_hash;
    logic [95:0]  job_tail;
    logic [31:0]  job_nonce_start, job_nonce_end, found_nonce;
    logic [5:0]   h_cnt;
    logic [511:0] h_data;
    logic         found_valid, found_ready, job_done, busy, overflow;

    logic         job_valid2, job_ready2, h_feedback2;
    logic [255:0] h_state2;
    logic [5:0]   h_cnt2;
    logic [511:0] h_data2;
    logic [31:0]  found_nonce2;
    logic         found_valid2, job_done2, busy2, overflow2;

    int errors = 0;
    int checks = 0;
    int c = 0;
    int stub_mode = 2;

    sha256_job_scheduler #(.LOOP_LOG2(2), .DIFFICULTY(16), .PIPE_LAT(PL), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_midstate(job_midstate), .job_tail(job_tail),
        .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
        .abort(abort), .h_cnt(h_cnt), .h_feedback(h_feedback), .h_state(h_state),
        .h_data(h_data), .h_hash(h_hash), .found_valid(found_valid),
        .found_ready(found_ready), .found_nonce(found_nonce), .job_done(job_done),
        .busy(busy), .overflow(overflow)
    );

    sha256_job_scheduler #(.LOOP_LOG2(0), .DIFFICULTY(16), .PIPE_LAT(5), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid2), .job_ready(job_ready2),
        .job_midstate(job_midstate), .job_tail(job_tail),
        .job_nonce_start(32'h0000_0077), .job_nonce_end(32'h0000_0077),
        .abort(1'b0), .h_cnt(h_cnt2), .h_feedback(h_feedback2), .h_state(h_state2),
        .h_data(h_data2), .h_hash(MISS_HASH), .found_valid(found_valid2),
        .found_ready(1'b0), .found_nonce(found_nonce2), .job_done(job_done2),
        .busy(busy2), .overflow(overflow2)
    );

    // Hasher stub: the hash seen now belongs to the nonce on h_data PL cycles ago.
    logic [31:0] pipe [PL];
    always @(posedge clk) begin
        pipe[0] <= h_data[127:96];
        for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
    assign h_hash = ((stub_mode == 1) || ((stub_mode == 0) && (pipe[PL-1] == 32'h5302)))
                    ? HIT_HASH : MISS_HASH;

    function automatic logic [511:0] exp_data(input logic [31:0] n, input logic [95:0] tail);
        return {32'h0000_0280, 320'h0, 32'h8000_0000, n, tail};
    endfunction

    task automatic step();
        @(negedge clk);
        c++;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] e, input int mode);
        check("accept_ready", job_ready, 1);
        stub_mode       = mode;
        job_midstate    = {8{s}};
        job_tail        = {3{~s}};
        job_nonce_start = s;
        job_nonce_end   = e;
        job_valid       = 1'b1;
        step();
        job_valid = 1'b0;
        c = 1;
        check("issue0_state", h_state, {8{s}});
        check("issue0_data", h_data, exp_data(s, {3{~s}}));
        check("issue0_cnt", h_cnt, 0);
        check("ready_drop", job_ready, 0);
        check("busy_set", busy, 1);
    endtask

    task automatic wait_done(input int exp, input string tag);
        while ((job_done !== 1'b1) && (c < 300)) step();
        check(tag, c, exp);
        check("done_not_ready", job_ready, 0);
        step();
        check("done_one_cycle", job_done, 0);
        check("ready_after_done", job_ready, 1);
    endtask

    initial begin
        job_valid = 0; abort = 0; found_ready = 0; job_valid2 = 0;
        job_midstate = '0; job_tail = '0; job_nonce_start = '0; job_nonce_end = '0;
        rst_n = 1'b0;
        step(); step(); step();
        check("rst_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cnt", h_cnt, 0);
        check("rst_fb", h_feedback, 0);
        check("rst_state", h_state, 0);
        check("rst_data", h_data, 0);
        check("rst_found", {found_valid, found_nonce}, 0);
        check("rst_done_ovf", {job_done, overflow}, 0);
        rst_n = 1'b1;
        repeat (PL + 5) step();

        // Single winner among 0x5300..0x5305.
        start_job(32'h5300, 32'h5305, 0);
        while (c <= 44) begin
            if (c <= 42) begin
                int idx;
                idx = (c - 1) / 4;
                if (idx > 5) idx = 5;
                check("t1_cnt", h_cnt, (c - 1) % 4);
                check("t1_fb", h_feedback, ((c - 1) % 4) != 0);
                check("t1_nonce", h_data[127:96], 32'h5300 + idx);
            end
            check("t1_done", job_done, c == 42);
            check("t1_ready", job_ready, c >= 43);
            check("t1_found_valid", found_valid, c >= 30);
            step();
        end
        check("t1_found_nonce", found_nonce, 32'h5302);
        check("t1_overflow", overflow, 0);
        found_ready = 1'b1;
        step();
        found_ready = 1'b0;
        check("t1_popped", found_valid, 0);

        // Nonce range wrapping through zero.
        start_job(32'hFFFF_FFFE, 32'h0000_0001, 2);
        while (c <= 16) begin
            logic [31:0] n;
            n = 32'hFFFF_FFFE + 32'((c - 1) / 4);
            check("t2_nonce", h_data[127:96], n);
            check("t2_fb", h_feedback, ((c - 1) % 4) != 0);
            step();
        end
        wait_done(34, "t2_done_cycle");
        check("t2_no_found", found_valid, 0);

        // Every nonce wins, FIFO never popped: 4 kept, 2 dropped.
        start_job(32'h100, 32'h105, 1);
        wait_done(42, "t3_done_cycle");
        check("t3_overflow", overflow, 1);
        check("t3_head", {found_valid, found_nonce}, {1'b1, 32'h100});
        start_job(32'h200, 32'h200, 2);
        check("t3_ovf_cleared", overflow, 0);
        check("t3_head_kept", {found_valid, found_nonce}, {1'b1, 32'h100});
        wait_done(22, "t3b_done_cycle");
        for (int i = 0; i < 4; i++) begin
            check("t3_order", {found_valid, found_nonce}, {1'b1, 32'h100 + 32'(i)});
            found_ready = 1'b1;
            step();
            found_ready = 1'b0;
        end
        check("t3_empty", found_valid, 0);

        // Abort three cycles after the first issue.
        start_job(32'h300, 32'h3FF, 2);
        while (c < 4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        while (c <= 21) begin
            check("t4_nonce_held", h_data[127:96], 32'h300);
            check("t4_no_done", job_done, 0);
            step();
        end
        wait_done(22, "t4_done_cycle");
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        // Asynchronous reset in the middle of a drain.
        start_job(32'h400, 32'h401, 1);
        while (c < 10) step();
        check("t5_busy_drain", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_ready_busy", {job_ready, busy}, 2'b10);
        check("t5_rst_cnt_fb", {h_cnt, h_feedback}, 0);
        check("t5_rst_state_data", {h_state, h_data}, 0);
        check("t5_rst_out", {found_valid, found_nonce, job_done, overflow}, 0);
        step(); step();
        rst_n = 1'b1;
        repeat (30) begin
            step();
            check("t5_no_done", {job_done, busy}, 0);
        end
        start_job(32'h500, 32'h500, 2);
        wait_done(22, "t5_new_job_done");

        // LOOP = 1: single nonce, no feedback ever.
        check("t6_ready", job_ready2, 1);
        job_valid2 = 1'b1;
        step();
        job_valid2 = 1'b0;
        c = 1;
        check("t6_nonce", h_data2[127:96], 32'h77);
        while (c <= 8) begin
            check("t6_cnt_fb", {h_cnt2, h_feedback2}, 0);
            check("t6_done", job_done2, c == 7);
            check("t6_busy", busy2, c <= 7);
            step();
        end
        check("t6_no_found", {found_valid2, overflow2}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
